// File: rtl/mandel_view_ctrl.sv
// Frame-level controller for the Mandelbrot renderer: owns the view
// (cx, cy, w in signed Q10.22), derives the renderer constants, clears the
// screen, starts and aborts renders, and muxes the VGA plot port.
module mandel_view_ctrl #(
  parameter int unsigned       WIDTH    = 320,
  parameter int unsigned       HEIGHT   = 240,
  parameter logic signed [31:0] W_RESET  = 32'sh01000000,
  parameter logic signed [31:0] W_MIN    = 32'sh00000400,
  parameter logic signed [31:0] W_MAX    = 32'sh02000000,
  parameter logic signed [31:0] C_LIMIT  = 32'sh02000000,
  parameter logic signed [31:0] DX_RECIP = 32'sd13107,
  parameter logic signed [31:0] DY_RECIP = 32'sd17476
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               zoom_in,
  input  logic               zoom_out,
  input  logic               pan_left,
  input  logic               pan_right,
  input  logic               pan_up,
  input  logic               pan_down,
  output logic signed [31:0] xmin,
  output logic signed [31:0] ymin,
  output logic signed [31:0] dx,
  output logic signed [31:0] dy,
  output logic               mb_start,
  output logic               mb_rst,
  input  logic               mb_done,
  input  logic [8:0]         mb_vga_x,
  input  logic [7:0]         mb_vga_y,
  input  logic [2:0]         mb_colour,
  input  logic               mb_plot,
  output logic [8:0]         vga_x,
  output logic [7:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned FRAC = 22;

  typedef enum logic [2:0] {
    S_CALC,
    S_CLEAR,
    S_RENDER,
    S_ABORT,
    S_APPLY,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    CMD_ZIN,
    CMD_ZOUT,
    CMD_PL,
    CMD_PR,
    CMD_PU,
    CMD_PD
  } cmd_t;

  state_t             state;
  cmd_t               pend_cmd;
  cmd_t               cmd_new;
  logic               pend_valid;
  logic               any_cmd;

  logic signed [31:0] cx;
  logic signed [31:0] cy;
  logic signed [31:0] w;
  logic signed [31:0] h;
  logic signed [31:0] w_half;
  logic signed [32:0] w_dbl;
  logic signed [32:0] cx_minus;
  logic signed [32:0] cx_plus;
  logic signed [32:0] cy_minus;
  logic signed [32:0] cy_plus;

  logic [8:0]         clr_x;
  logic [7:0]         clr_y;
  logic               last_x;
  logic               last_pix;

  // Q10.22 multiply by a reciprocal constant, keeping the low 32 bits
  function automatic logic signed [31:0] scale(input logic signed [31:0] a,
                                               input logic signed [31:0] r);
    return 32'((64'(a) * 64'(r)) >>> FRAC);
  endfunction

  // clamp a widened pan result to [-C_LIMIT, C_LIMIT]
  function automatic logic signed [31:0] sat(input logic signed [32:0] v);
    if (v > 33'(C_LIMIT)) begin
      return C_LIMIT;
    end else if (v < -33'(C_LIMIT)) begin
      return -C_LIMIT;
    end else begin
      return 32'(v);
    end
  endfunction

  // view-derived quantities and candidate command results
  always_comb begin
    h        = (w >>> 1) + (w >>> 2);
    w_half   = w >>> 1;
    w_dbl    = 33'(w) <<< 1;
    cx_minus = 33'(cx) - 33'(w >>> 3);
    cx_plus  = 33'(cx) + 33'(w >>> 3);
    cy_minus = 33'(cy) - 33'(h >>> 3);
    cy_plus  = 33'(cy) + 33'(h >>> 3);
  end

  // same-cycle command priority encoder
  always_comb begin
    any_cmd = zoom_in | zoom_out | pan_left | pan_right | pan_up | pan_down;
    cmd_new = CMD_PD;
    if (zoom_in) begin
      cmd_new = CMD_ZIN;
    end else if (zoom_out) begin
      cmd_new = CMD_ZOUT;
    end else if (pan_left) begin
      cmd_new = CMD_PL;
    end else if (pan_right) begin
      cmd_new = CMD_PR;
    end else if (pan_up) begin
      cmd_new = CMD_PU;
    end
  end

  assign last_x   = (clr_x == 9'(WIDTH - 1));
  assign last_pix = last_x && (clr_y == 8'(HEIGHT - 1));

  // frame sequencer, view state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CALC;
      cx         <= '0;
      cy         <= '0;
      w          <= W_RESET;
      pend_valid <= 1'b0;
      pend_cmd   <= CMD_ZIN;
      clr_x      <= '0;
      clr_y      <= '0;
      xmin       <= '0;
      ymin       <= '0;
      dx         <= '0;
      dy         <= '0;
      mb_start   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mb_start   <= 1'b0;
      frame_done <= 1'b0;

      // one-entry command slot: later pulses are dropped while it is full
      if (!pend_valid && any_cmd) begin
        pend_valid <= 1'b1;
        pend_cmd   <= cmd_new;
      end

      case (state)
        S_CALC: begin
          xmin  <= cx - (w >>> 1);
          ymin  <= cy - (h >>> 1);
          dx    <= scale(w, DX_RECIP);
          dy    <= scale(h, DY_RECIP);
          clr_x <= '0;
          clr_y <= '0;
          state <= S_CLEAR;
        end

        S_CLEAR: begin
          if (last_pix) begin
            if (pend_valid) begin
              state <= S_APPLY;
            end else begin
              state    <= S_RENDER;
              mb_start <= 1'b1;
            end
          end else if (last_x) begin
            clr_x <= '0;
            clr_y <= clr_y + 8'd1;
          end else begin
            clr_x <= clr_x + 9'd1;
          end
        end

        S_RENDER: begin
          // a finished frame wins over a command arriving in the same cycle
          if (mb_done) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end else if (pend_valid) begin
            state <= S_ABORT;
          end
        end

        S_ABORT: begin
          state <= S_APPLY;
        end

        S_APPLY: begin
          pend_valid <= 1'b0;
          state      <= S_CALC;
          case (pend_cmd)
            CMD_ZIN:  if (w_half >= W_MIN) w <= w_half;
            CMD_ZOUT: if (w_dbl <= 33'(W_MAX)) w <= 32'(w_dbl);
            CMD_PL:   cx <= sat(cx_minus);
            CMD_PR:   cx <= sat(cx_plus);
            CMD_PU:   cy <= sat(cy_minus);
            CMD_PD:   cy <= sat(cy_plus);
            default:  ;
          endcase
        end

        S_DONE: begin
          if (pend_valid) begin
            state <= S_APPLY;
          end
        end

        default: begin
          state <= S_CALC;
        end
      endcase
    end
  end

  // VGA port mux: own clear sweep, renderer stream, or idle
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    if (state == S_CLEAR) begin
      vga_x    = clr_x;
      vga_y    = clr_y;
      vga_plot = 1'b1;
    end else if (state == S_RENDER) begin
      vga_x      = mb_vga_x;
      vga_y      = mb_vga_y;
      vga_colour = mb_colour;
      vga_plot   = mb_plot;
    end
  end

  assign mb_rst = rst | (state == S_ABORT);
  assign busy   = (state != S_DONE);

endmodule

// File: tb/tb_mandel_view_ctrl.sv
// Directed testbench for mandel_view_ctrl, run on a reduced screen so every
// clear sweep is short; the arithmetic constants keep their full-size values.
module tb_mandel_view_ctrl;

  localparam int unsigned TW     = 16;
  localparam int unsigned TH     = 8;
  localparam int          NPIX   = TW * TH;
  localparam int          BUDGET = NPIX + 64;

  logic               clk;
  logic               rst;
  logic               zoom_in, zoom_out, pan_left, pan_right, pan_up, pan_down;
  logic signed [31:0] xmin, ymin, dx, dy;
  logic               mb_start, mb_rst, mb_done, mb_plot;
  logic [8:0]         mb_vga_x, vga_x;
  logic [7:0]         mb_vga_y, vga_y;
  logic [2:0]         mb_colour, vga_colour;
  logic               vga_plot, busy, frame_done;

  int checks;
  int failures;

  mandel_view_ctrl #(.WIDTH(TW), .HEIGHT(TH)) dut (
    .clk(clk), .rst(rst),
    .zoom_in(zoom_in), .zoom_out(zoom_out), .pan_left(pan_left),
    .pan_right(pan_right), .pan_up(pan_up), .pan_down(pan_down),
    .xmin(xmin), .ymin(ymin), .dx(dx), .dy(dy),
    .mb_start(mb_start), .mb_rst(mb_rst), .mb_done(mb_done),
    .mb_vga_x(mb_vga_x), .mb_vga_y(mb_vga_y), .mb_colour(mb_colour),
    .mb_plot(mb_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // advance until mb_start is seen or the budget runs out; n = cycles taken
  task automatic run_until_start(output int n);
    n = 0;
    while (mb_start !== 1'b1 && n < BUDGET) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_cmd(input int c);
    case (c)
      0: zoom_in   = 1'b1;
      1: zoom_out  = 1'b1;
      2: pan_left  = 1'b1;
      3: pan_right = 1'b1;
      4: pan_up    = 1'b1;
      default: pan_down = 1'b1;
    endcase
    step();
    {zoom_in, zoom_out, pan_left, pan_right, pan_up, pan_down} = '0;
  endtask

  // end the running frame, issue a command in DONE, wait for the next start
  task automatic finish_and_cmd(input int c, output int n);
    mb_done = 1'b1;
    step();
    mb_done = 1'b0;
    pulse_cmd(c);
    run_until_start(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({vga_plot, mb_start, frame_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs plot/start/done got=%b exp=000", {vga_plot, mb_start, frame_done});
    end
    checks++;
    if (mb_rst !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mb_rst_busy got=%b%b exp=11", mb_rst, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_frame();
    int n, lx, ly, bad;
    step();
    checks++;
    if ({xmin, ymin} !== {32'hFF800000, 32'hFFA00000}) begin
      failures++;
      $display("FAIL first_xmin_ymin got=%h %h exp=ff800000 ffa00000", xmin, ymin);
    end
    checks++;
    if (dx !== 32'sd52428 || dy !== 32'sd52428) begin
      failures++;
      $display("FAIL first_dx_dy got=%0d %0d exp=52428 52428", dx, dy);
    end
    checks++;
    if (vga_plot !== 1'b1 || vga_x !== 9'd0 || vga_y !== 8'd0) begin
      failures++;
      $display("FAIL clear_first_pixel got=%b (%0d,%0d) exp=1 (0,0)", vga_plot, vga_x, vga_y);
    end
    n = 0; lx = 0; ly = 0; bad = 0;
    while (vga_plot === 1'b1 && n < BUDGET) begin
      if (vga_colour !== 3'd0) bad++;
      lx = int'(vga_x);
      ly = int'(vga_y);
      n++;
      step();
    end
    checks++;
    if (n !== NPIX || bad !== 0) begin
      failures++;
      $display("FAIL clear_count got=%0d badcolour=%0d exp=%0d 0", n, bad, NPIX);
    end
    checks++;
    if (lx !== TW - 1 || ly !== TH - 1) begin
      failures++;
      $display("FAIL clear_last_pixel got=(%0d,%0d) exp=(%0d,%0d)", lx, ly, TW - 1, TH - 1);
    end
    checks++;
    if (mb_start !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL first_start got=%b busy=%b exp=1 1", mb_start, busy);
    end
    step();
    checks++;
    if (mb_start !== 1'b0) begin
      failures++;
      $display("FAIL start_one_cycle got=%b exp=0", mb_start);
    end
  endtask

  task automatic test_render();
    logic [8:0] vx [3] = '{9'd0, 9'd171, 9'd319};
    logic [7:0] vy [3] = '{8'd0, 8'd90, 8'd239};
    logic [2:0] vc [3] = '{3'd7, 3'd2, 3'd5};
    for (int i = 0; i < 3; i++) begin
      mb_vga_x  = vx[i];
      mb_vga_y  = vy[i];
      mb_colour = vc[i];
      mb_plot   = (i != 1);
      #1;
      checks++;
      if ({vga_x, vga_y, vga_colour, vga_plot} !== {vx[i], vy[i], vc[i], 1'(i != 1)}) begin
        failures++;
        $display("FAIL render_mirror[%0d] got=%0d %0d %0d %b exp=%0d %0d %0d %b", i,
                 vga_x, vga_y, vga_colour, vga_plot, vx[i], vy[i], vc[i], 1'(i != 1));
      end
      step();
    end
    mb_plot = 1'b0;
    mb_done = 1'b1;
    step();
    mb_done = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_done_pulse got=%b busy=%b exp=1 0", frame_done, busy);
    end
    step();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || vga_plot !== 1'b0) begin
      failures++;
      $display("FAIL done_idle got=%b%b%b exp=000", frame_done, busy, vga_plot);
    end
  endtask

  task automatic test_zoom_in_done();
    int n;
    pulse_cmd(0);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL zin_capture_in_done busy got=%b exp=0", busy);
    end
    step();
    checks++;
    if (busy !== 1'b1 || vga_plot !== 1'b0 || xmin !== 32'hFF800000) begin
      failures++;
      $display("FAIL zin_apply got=%b %b %h exp=1 0 ff800000", busy, vga_plot, xmin);
    end
    step();
    checks++;
    if (vga_plot !== 1'b0 || xmin !== 32'hFF800000) begin
      failures++;
      $display("FAIL zin_calc got=%b %h exp=0 ff800000", vga_plot, xmin);
    end
    step();
    checks++;
    if (vga_plot !== 1'b1 || {xmin, ymin} !== {32'hFFC00000, 32'hFFD00000}) begin
      failures++;
      $display("FAIL zin_view got=%b %h %h exp=1 ffc00000 ffd00000", vga_plot, xmin, ymin);
    end
    checks++;
    if (dx !== 32'sd26214 || dy !== 32'sd26214) begin
      failures++;
      $display("FAIL zin_dx_dy got=%0d %0d exp=26214 26214", dx, dy);
    end
    run_until_start(n);
    checks++;
    if (n !== NPIX || mb_start !== 1'b1) begin
      failures++;
      $display("FAIL zin_rerender got=%0d start=%b exp=%0d 1", n, mb_start, NPIX);
    end
  endtask

  task automatic test_pan_abort();
    int n;
    do_reset();
    run_until_start(n);
    mb_plot   = 1'b1;
    mb_colour = 3'd5;
    step();
    step();
    pulse_cmd(3);
    checks++;
    if (mb_rst !== 1'b0 || vga_plot !== 1'b1) begin
      failures++;
      $display("FAIL pan_still_render got=%b %b exp=0 1", mb_rst, vga_plot);
    end
    step();
    checks++;
    if (mb_rst !== 1'b1 || vga_plot !== 1'b0) begin
      failures++;
      $display("FAIL pan_abort got=%b %b exp=1 0", mb_rst, vga_plot);
    end
    mb_plot = 1'b0;
    step();
    checks++;
    if (mb_rst !== 1'b0) begin
      failures++;
      $display("FAIL abort_one_cycle got=%b exp=0", mb_rst);
    end
    step();
    step();
    checks++;
    if ({xmin, ymin} !== {32'hFFA00000, 32'hFFA00000} || dx !== 32'sd52428) begin
      failures++;
      $display("FAIL pan_right_view got=%h %h %0d exp=ffa00000 ffa00000 52428", xmin, ymin, dx);
    end
    run_until_start(n);
    checks++;
    if (n !== NPIX || mb_start !== 1'b1) begin
      failures++;
      $display("FAIL pan_restart got=%0d start=%b exp=%0d 1", n, mb_start, NPIX);
    end
  endtask

  task automatic test_zoom_out_priority();
    int n;
    zoom_out = 1'b1;
    pan_up   = 1'b1;
    step();
    zoom_out = 1'b0;
    pan_up   = 1'b0;
    pulse_cmd(5);
    checks++;
    if (mb_rst !== 1'b1) begin
      failures++;
      $display("FAIL zout_abort got=%b exp=1", mb_rst);
    end
    step();
    step();
    step();
    checks++;
    if ({xmin, ymin} !== {32'hFF200000, 32'hFF400000}) begin
      failures++;
      $display("FAIL zout_view got=%h %h exp=ff200000 ff400000", xmin, ymin);
    end
    checks++;
    if (dx !== 32'sd104856 || dy !== 32'sd104856) begin
      failures++;
      $display("FAIL zout_dx_dy got=%0d %0d exp=104856 104856", dx, dy);
    end
    run_until_start(n);
    checks++;
    if (n !== NPIX || mb_start !== 1'b1) begin
      failures++;
      $display("FAIL pan_down_dropped got=%0d start=%b exp=%0d 1", n, mb_start, NPIX);
    end
  endtask

  task automatic test_zoom_out_limit();
    int n;
    finish_and_cmd(1, n);
    checks++;
    if (n !== NPIX + 3 || mb_start !== 1'b1) begin
      failures++;
      $display("FAIL zout_blocked_rerender got=%0d start=%b exp=%0d 1", n, mb_start, NPIX + 3);
    end
    checks++;
    if (xmin !== 32'hFF200000 || dx !== 32'sd104856) begin
      failures++;
      $display("FAIL zout_blocked_view got=%h %0d exp=ff200000 104856", xmin, dx);
    end
  endtask

  task automatic test_pan_saturate();
    int n;
    logic signed [31:0] x7;
    x7 = '0;
    for (int i = 0; i < 8; i++) begin
      finish_and_cmd(3, n);
      if (i == 6) x7 = xmin;
    end
    checks++;
    if (x7 !== 32'h00E00000) begin
      failures++;
      $display("FAIL pan_before_limit got=%h exp=00e00000", x7);
    end
    checks++;
    if ({xmin, ymin} !== {32'h01000000, 32'hFF400000} || mb_start !== 1'b1) begin
      failures++;
      $display("FAIL pan_saturated got=%h %h %b exp=01000000 ff400000 1", xmin, ymin, mb_start);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    mb_done = 1'b1;
    step();
    mb_done = 1'b0;
    pulse_cmd(0);
    step();
    step();
    step();
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (vga_plot !== 1'b1 || vga_x !== 9'd10 || vga_y !== 8'd0) begin
      failures++;
      $display("FAIL mid_clear_pos got=%b (%0d,%0d) exp=1 (10,0)", vga_plot, vga_x, vga_y);
    end
    rst = 1'b1;
    step();
    checks++;
    if (vga_plot !== 1'b0 || mb_rst !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_clear got=%b %b exp=0 1", vga_plot, mb_rst);
    end
    rst = 1'b0;
    step();
    checks++;
    if (vga_plot !== 1'b1 || vga_x !== 9'd0 || vga_y !== 8'd0) begin
      failures++;
      $display("FAIL clear_restart got=%b (%0d,%0d) exp=1 (0,0)", vga_plot, vga_x, vga_y);
    end
    checks++;
    if ({xmin, ymin} !== {32'hFF800000, 32'hFFA00000} || dx !== 32'sd52428 || dy !== 32'sd52428) begin
      failures++;
      $display("FAIL rst_view got=%h %h %0d %0d exp=ff800000 ffa00000 52428 52428", xmin, ymin, dx, dy);
    end
    run_until_start(n);
    checks++;
    if (n !== NPIX || mb_start !== 1'b1) begin
      failures++;
      $display("FAIL rst_rerender got=%0d start=%b exp=%0d 1", n, mb_start, NPIX);
    end
  endtask

  task automatic test_zoom_min();
    int n;
    for (int i = 0; i < 14; i++) finish_and_cmd(0, n);
    checks++;
    if ({xmin, ymin} !== {32'hFFFFFE00, 32'hFFFFFE80} || dx !== 32'sd3 || dy !== 32'sd3) begin
      failures++;
      $display("FAIL zoom_at_min got=%h %h %0d %0d exp=fffffe00 fffffe80 3 3", xmin, ymin, dx, dy);
    end
    finish_and_cmd(0, n);
    checks++;
    if (xmin !== 32'hFFFFFE00 || n !== NPIX + 3 || mb_start !== 1'b1) begin
      failures++;
      $display("FAIL zoom_min_blocked got=%h %0d %b exp=fffffe00 %0d 1", xmin, n, mb_start, NPIX + 3);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    {zoom_in, zoom_out, pan_left, pan_right, pan_up, pan_down} = '0;
    mb_done   = 1'b0;
    mb_vga_x  = '0;
    mb_vga_y  = '0;
    mb_colour = '0;
    mb_plot   = 1'b0;

    test_reset();
    test_first_frame();
    test_render();
    test_zoom_in_done();
    test_pan_abort();
    test_zoom_out_priority();
    test_zoom_out_limit();
    test_pan_saturate();
    test_reset_mid_clear();
    test_zoom_min();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
